// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI peripheral slice.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int SYNC_STAGES = 2;
  localparam int MAX_WORDS   = 4;

  function automatic int bit_cnt_w(input int data_bits);
    return (data_bits > 1) ? $clog2(data_bits) : 1;
  endfunction

  function automatic int word_cnt_w(input int num_words);
    return $clog2(num_words + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus one history flop
// that yields single-cycle rise/fall strobes on the synchronized signal.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      prev_q <= RESET_VALUE;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI slave, oversampled on clk: shifts preloaded words out on MISO
// and captures up to NUM_WORDS MOSI words per SS-low frame.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int NUM_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SCK,
  input  logic                 SS,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic [DATA_BITS-1:0] tx_word0,
  input  logic [DATA_BITS-1:0] tx_word1,
  input  logic [DATA_BITS-1:0] tx_word2,
  input  logic [DATA_BITS-1:0] tx_word3,
  output logic [DATA_BITS-1:0] received_word0,
  output logic [DATA_BITS-1:0] received_word1,
  output logic [DATA_BITS-1:0] received_word2,
  output logic [DATA_BITS-1:0] received_word3,
  output logic                 word_done,
  output logic                 frame_done,
  output logic [2:0]           words_rcvd,
  output logic                 busy
);

  localparam int BCW = bit_cnt_w(DATA_BITS);
  localparam int WCW = word_cnt_w(NUM_WORDS);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic [WCW-1:0] WORDS_MAX = WCW'(NUM_WORDS);

  logic sck_sync, sck_rise, sck_fall;
  logic ss_sync, ss_rise, ss_fall;

  spi_sync_edge #(.RESET_VALUE(1'b0)) u_sck_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (SCK),
    .sync_out (sck_sync),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_sync_edge #(.RESET_VALUE(1'b1)) u_ss_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (SS),
    .sync_out (ss_sync),
    .rise     (ss_rise),
    .fall     (ss_fall)
  );

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic [SYNC_STAGES-1:0] flush_q, flush_d;
  logic                   armed_q, armed_d;
  logic                   miso_q, miso_d;
  logic [DATA_BITS-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_BITS-2:0]   rx_sr_q, rx_sr_d;
  logic [DATA_BITS-1:0]   tx_buf_q [MAX_WORDS];
  logic [DATA_BITS-1:0]   tx_buf_d [MAX_WORDS];
  logic [DATA_BITS-1:0]   rx_word_q [MAX_WORDS];
  logic [DATA_BITS-1:0]   rx_word_d [MAX_WORDS];
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]         word_cnt_q, word_cnt_d;
  logic                   word_done_q, word_done_d;
  logic                   frame_done_q, frame_done_d;

  logic                   mosi_sync;
  logic [DATA_BITS-1:0]   rx_full;
  logic [1:0]             idx;

  assign mosi_sync = mosi_q[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    mosi_d       = {mosi_q[SYNC_STAGES-2:0], MOSI};
    flush_d      = {flush_q[SYNC_STAGES-2:0], 1'b1};
    armed_d      = armed_q;
    miso_d       = miso_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    tx_buf_d     = tx_buf_q;
    rx_word_d    = rx_word_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    word_done_d  = 1'b0;
    frame_done_d = 1'b0;
    rx_full      = {rx_sr_q, mosi_sync};
    idx          = 2'(word_cnt_q);

    // A frame may only start once the synchronizers hold real samples and
    // the link has been seen idle, so a stale SS-low at reset release is ignored.
    if (flush_q[SYNC_STAGES-1] && ss_sync && !sck_sync) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall && armed_q) begin
          tx_buf_d   = '{tx_word0, tx_word1, tx_word2, tx_word3};
          tx_sr_d    = tx_word0;
          miso_d     = tx_word0[DATA_BITS-1];
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          frame_done_d = 1'b1;
          miso_d       = 1'b0;
          state_d      = IDLE;
        end else if (sck_rise) begin
          rx_sr_d = rx_full[DATA_BITS-2:0];
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (word_cnt_q < WORDS_MAX) begin
              rx_word_d[idx] = rx_full;
              word_done_d    = 1'b1;
              word_cnt_d     = word_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          // A zero bit count here means a word boundary was just crossed.
          if (word_cnt_q >= WORDS_MAX) begin
            miso_d = 1'b0;
          end else if (bit_cnt_q == '0) begin
            tx_sr_d = tx_buf_q[idx];
            miso_d  = tx_buf_q[idx][DATA_BITS-1];
          end else begin
            tx_sr_d = tx_sr_q << 1;
            miso_d  = tx_sr_q[DATA_BITS-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the small word arrays are reset too, because received words must read zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mosi_q       <= '0;
      flush_q      <= '0;
      armed_q      <= 1'b0;
      miso_q       <= 1'b0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      tx_buf_q     <= '{default: '0};
      rx_word_q    <= '{default: '0};
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      word_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mosi_q       <= mosi_d;
      flush_q      <= flush_d;
      armed_q      <= armed_d;
      miso_q       <= miso_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      tx_buf_q     <= tx_buf_d;
      rx_word_q    <= rx_word_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      word_done_q  <= word_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign MISO           = miso_q;
  assign received_word0 = rx_word_q[0];
  assign received_word1 = rx_word_q[1];
  assign received_word2 = rx_word_q[2];
  assign received_word3 = rx_word_q[3];
  assign word_done      = word_done_q;
  assign frame_done     = frame_done_q;
  assign words_rcvd     = 3'(word_cnt_q);
  assign busy           = (state_q == SHIFT);

endmodule
